exmem_stage: RTL and testbench

- EX/MEM pipeline register and memory-request front end; the receiving end of the execute stage's outputs.
- Captures EX-stage control, data and destination fields.
- Evaluates traps and address alignment, and generates store lanes and byte enables for the data cache.
- Tracks the LL/SC link bit and presents registered MEM-stage signals to the MEM stage and writeback.

---
 rtl/exmem_stage.sv | 182 ++++++++++++++++++
 tb/tb_exmem_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register and data-cache request front end: traps, alignment,
// store lane steering, LL/SC link tracking and the registered MEM-stage view.
module exmem_stage #(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        LLClear,
    input  logic        EX_Trap,
    input  logic        EX_TrapCond,
    input  logic        EX_LLSC,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_MemHalf,
    input  logic        EX_MemByte,
    input  logic        EX_MemSignExtend,
    input  logic        EX_RegWrite,
    input  logic        EX_MemtoReg,
    input  logic        EX_ExcOv,
    input  logic [31:0] EX_ALUResult,
    input  logic [31:0] EX_ReadData2,
    input  logic [4:0]  EX_RegDstOut,
    output logic        M_MemRead,
    output logic        M_MemWrite,
    output logic [3:0]  M_ByteEnable,
    output logic [31:0] M_StoreData,
    output logic        M_MemHalf,
    output logic        M_MemByte,
    output logic        M_MemSignExtend,
    output logic        M_MemtoReg,
    output logic        M_RegWrite,
    output logic [31:0] M_ALUResult,
    output logic [4:0]  M_RegDstOut,
    output logic        M_ExcAdEL,
    output logic        M_ExcAdES,
    output logic        M_ExcTrap,
    output logic        M_ExcOv,
    output logic        M_Exception,
    output logic        LLBit
);

    function automatic logic [3:0] laneEnables(input logic isByte, input logic isHalf,
                                               input logic [1:0] addrLo);
        if (isByte)
            return 4'b0001 << addrLo;
        else if (isHalf)
            return addrLo[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] replicateStore(input logic isByte, input logic isHalf,
                                                   input logic [31:0] rt);
        if (isByte)
            return {4{rt[7:0]}};
        else if (isHalf)
            return {2{rt[15:0]}};
        else
            return rt;
    endfunction

    // Stage p0: decode of the EX-stage fields before capture
    logic        misaligned_p0;
    logic        adEL_p0;
    logic        adES_p0;
    logic        excTrap_p0;
    logic [3:0]  byteEn_p0;
    logic [31:0] storeData_p0;

    always_comb begin
        misaligned_p0 = 1'b0;
        if (ALIGN_CHECK != 0)
            misaligned_p0 = EX_MemHalf ? EX_ALUResult[0]
                                       : (~EX_MemByte & (EX_ALUResult[1:0] != 2'b00));
        adEL_p0      = EX_MemRead & misaligned_p0;
        adES_p0      = EX_MemWrite & misaligned_p0;
        excTrap_p0   = EX_Trap & ((|EX_ALUResult) == EX_TrapCond);
        byteEn_p0    = 4'b0000;
        if (EX_MemRead | EX_MemWrite)
            byteEn_p0 = laneEnables(EX_MemByte, EX_MemHalf, EX_ALUResult[1:0]);
        storeData_p0 = replicateStore(EX_MemByte, EX_MemHalf, EX_ReadData2);
    end

    // Stage p1: MEM-stage register
    logic        memRead_p1;
    logic        memWrite_p1;
    logic        memHalf_p1;
    logic        memByte_p1;
    logic        memSignExtend_p1;
    logic        regWrite_p1;
    logic        memtoReg_p1;
    logic        llsc_p1;
    logic        adEL_p1;
    logic        adES_p1;
    logic        excTrap_p1;
    logic        excOv_p1;
    logic [3:0]  byteEn_p1;
    logic [31:0] storeData_p1;
    logic [31:0] aluResult_p1;
    logic [4:0]  regDst_p1;

    always_ff @(posedge clock) begin
        if (reset || Flush) begin
            memRead_p1       <= 1'b0;
            memWrite_p1      <= 1'b0;
            memHalf_p1       <= 1'b0;
            memByte_p1       <= 1'b0;
            memSignExtend_p1 <= 1'b0;
            regWrite_p1      <= 1'b0;
            memtoReg_p1      <= 1'b0;
            llsc_p1          <= 1'b0;
            adEL_p1          <= 1'b0;
            adES_p1          <= 1'b0;
            excTrap_p1       <= 1'b0;
            excOv_p1         <= 1'b0;
            byteEn_p1        <= 4'b0000;
            storeData_p1     <= 32'd0;
            aluResult_p1     <= 32'd0;
            regDst_p1        <= 5'd0;
        end else if (!Stall) begin
            memRead_p1       <= EX_MemRead;
            memWrite_p1      <= EX_MemWrite;
            memHalf_p1       <= EX_MemHalf;
            memByte_p1       <= EX_MemByte;
            memSignExtend_p1 <= EX_MemSignExtend;
            regWrite_p1      <= EX_RegWrite;
            memtoReg_p1      <= EX_MemtoReg;
            llsc_p1          <= EX_LLSC;
            adEL_p1          <= adEL_p0;
            adES_p1          <= adES_p0;
            excTrap_p1       <= excTrap_p0;
            excOv_p1         <= EX_ExcOv;
            byteEn_p1        <= byteEn_p0;
            storeData_p1     <= storeData_p0;
            aluResult_p1     <= EX_ALUResult;
            regDst_p1        <= EX_RegDstOut;
        end
    end

    logic excAny;
    logic llMem;
    logic scMem;

    always_comb begin
        excAny = adEL_p1 | adES_p1 | excTrap_p1 | excOv_p1;
        llMem  = llsc_p1 & memRead_p1;
        scMem  = llsc_p1 & memWrite_p1;
    end

    // Link bit moves only on ordinary advancing edges; a flush leaves it alone.
    always_ff @(posedge clock) begin
        if (reset)
            LLBit <= 1'b0;
        else if (!Flush && !Stall) begin
            if (LLClear || scMem)
                LLBit <= 1'b0;
            else if (llMem && !excAny)
                LLBit <= 1'b1;
        end
    end

    // A failing SC still writes its status register but never touches memory.
    assign M_MemRead       = memRead_p1 & ~excAny;
    assign M_MemWrite      = memWrite_p1 & ~excAny & (~scMem | LLBit);
    assign M_ByteEnable    = (excAny | (scMem & ~LLBit)) ? 4'b0000 : byteEn_p1;
    assign M_StoreData     = storeData_p1;
    assign M_MemHalf       = memHalf_p1;
    assign M_MemByte       = memByte_p1;
    assign M_MemSignExtend = memSignExtend_p1;
    assign M_MemtoReg      = memtoReg_p1 & ~scMem;
    assign M_RegWrite      = (regWrite_p1 | scMem) & ~excAny;
    assign M_ALUResult     = scMem ? {31'd0, LLBit} : aluResult_p1;
    assign M_RegDstOut     = regDst_p1;
    assign M_ExcAdEL       = adEL_p1;
    assign M_ExcAdES       = adES_p1;
    assign M_ExcTrap       = excTrap_p1;
    assign M_ExcOv         = excOv_p1;
    assign M_Exception     = excAny;

endmodule

// File: tb/tb_exmem_stage.sv
// Bench for exmem_stage: two instances (alignment checking on and off) driven
// in lockstep, checked every cycle against a behavioural model plus literal pins.
module tb_exmem_stage;

    typedef struct packed {
        logic        rd, wr, half, byt, sext, rw, m2r, llsc, trap, tcond, ov;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  dst;
    } ex_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic Stall = 1'b0, Flush = 1'b0, LLClear = 1'b0;
    ex_t  ex = '0;

    int tests = 0;
    int fails = 0;

    logic        A_MemRead, A_MemWrite, A_MemHalf, A_MemByte, A_MemSignExtend, A_MemtoReg, A_RegWrite;
    logic [3:0]  A_ByteEnable;
    logic [31:0] A_StoreData, A_ALUResult;
    logic [4:0]  A_RegDstOut;
    logic        A_ExcAdEL, A_ExcAdES, A_ExcTrap, A_ExcOv, A_Exception, A_LLBit;
    logic        B_MemRead, B_MemWrite, B_MemHalf, B_MemByte, B_MemSignExtend, B_MemtoReg, B_RegWrite;
    logic [3:0]  B_ByteEnable;
    logic [31:0] B_StoreData, B_ALUResult;
    logic [4:0]  B_RegDstOut;
    logic        B_ExcAdEL, B_ExcAdES, B_ExcTrap, B_ExcOv, B_Exception, B_LLBit;

    exmem_stage #(.ALIGN_CHECK(1)) dutA (
        .clock(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .LLClear(LLClear),
        .EX_Trap(ex.trap), .EX_TrapCond(ex.tcond), .EX_LLSC(ex.llsc),
        .EX_MemRead(ex.rd), .EX_MemWrite(ex.wr), .EX_MemHalf(ex.half), .EX_MemByte(ex.byt),
        .EX_MemSignExtend(ex.sext), .EX_RegWrite(ex.rw), .EX_MemtoReg(ex.m2r), .EX_ExcOv(ex.ov),
        .EX_ALUResult(ex.alu), .EX_ReadData2(ex.rt), .EX_RegDstOut(ex.dst),
        .M_MemRead(A_MemRead), .M_MemWrite(A_MemWrite), .M_ByteEnable(A_ByteEnable),
        .M_StoreData(A_StoreData), .M_MemHalf(A_MemHalf), .M_MemByte(A_MemByte),
        .M_MemSignExtend(A_MemSignExtend), .M_MemtoReg(A_MemtoReg), .M_RegWrite(A_RegWrite),
        .M_ALUResult(A_ALUResult), .M_RegDstOut(A_RegDstOut), .M_ExcAdEL(A_ExcAdEL),
        .M_ExcAdES(A_ExcAdES), .M_ExcTrap(A_ExcTrap), .M_ExcOv(A_ExcOv),
        .M_Exception(A_Exception), .LLBit(A_LLBit)
    );

    exmem_stage #(.ALIGN_CHECK(0)) dutB (
        .clock(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .LLClear(LLClear),
        .EX_Trap(ex.trap), .EX_TrapCond(ex.tcond), .EX_LLSC(ex.llsc),
        .EX_MemRead(ex.rd), .EX_MemWrite(ex.wr), .EX_MemHalf(ex.half), .EX_MemByte(ex.byt),
        .EX_MemSignExtend(ex.sext), .EX_RegWrite(ex.rw), .EX_MemtoReg(ex.m2r), .EX_ExcOv(ex.ov),
        .EX_ALUResult(ex.alu), .EX_ReadData2(ex.rt), .EX_RegDstOut(ex.dst),
        .M_MemRead(B_MemRead), .M_MemWrite(B_MemWrite), .M_ByteEnable(B_ByteEnable),
        .M_StoreData(B_StoreData), .M_MemHalf(B_MemHalf), .M_MemByte(B_MemByte),
        .M_MemSignExtend(B_MemSignExtend), .M_MemtoReg(B_MemtoReg), .M_RegWrite(B_RegWrite),
        .M_ALUResult(B_ALUResult), .M_RegDstOut(B_RegDstOut), .M_ExcAdEL(B_ExcAdEL),
        .M_ExcAdES(B_ExcAdES), .M_ExcTrap(B_ExcTrap), .M_ExcOv(B_ExcOv),
        .M_Exception(B_Exception), .LLBit(B_LLBit)
    );

    logic [85:0] outA, outB;
    assign outA = {A_MemRead, A_MemWrite, A_ByteEnable, A_StoreData, A_MemHalf, A_MemByte,
                   A_MemSignExtend, A_MemtoReg, A_RegWrite, A_ALUResult, A_RegDstOut,
                   A_ExcAdEL, A_ExcAdES, A_ExcTrap, A_ExcOv, A_Exception, A_LLBit};
    assign outB = {B_MemRead, B_MemWrite, B_ByteEnable, B_StoreData, B_MemHalf, B_MemByte,
                   B_MemSignExtend, B_MemtoReg, B_RegWrite, B_ALUResult, B_RegDstOut,
                   B_ExcAdEL, B_ExcAdES, B_ExcTrap, B_ExcOv, B_Exception, B_LLBit};

    always #5 clk = ~clk;

    // What the MEM stage must present for instruction s with link bit ll.
    function automatic logic [85:0] expOut(input ex_t s, input logic ll, input bit align);
        logic [1:0]  a;
        logic        mis, adel, ades, trp, exc, sc;
        logic [3:0]  be;
        logic [31:0] sd;
        a    = s.alu[1:0];
        mis  = align && (s.half ? a[0] : (!s.byt && a != 2'b00));
        adel = s.rd && mis;
        ades = s.wr && mis;
        trp  = s.trap && ((s.alu != 0) == s.tcond);
        exc  = adel || ades || trp || s.ov;
        sc   = s.llsc && s.wr;
        be   = 4'b0000;
        if (s.rd || s.wr) begin
            if (s.byt)       be = 4'b0001 << a;
            else if (s.half) be = a[1] ? 4'b1100 : 4'b0011;
            else             be = 4'b1111;
        end
        if (exc || (sc && !ll)) be = 4'b0000;
        if (s.byt)       sd = {4{s.rt[7:0]}};
        else if (s.half) sd = {2{s.rt[15:0]}};
        else             sd = s.rt;
        return {s.rd && !exc, s.wr && !exc && (!sc || ll), be, sd, s.half, s.byt, s.sext,
                s.m2r && !sc, (s.rw || sc) && !exc, sc ? {31'd0, ll} : s.alu, s.dst,
                adel, ades, trp, s.ov, exc, ll};
    endfunction

    ex_t  mA = '0, mB = '0;
    logic llA = 1'b0, llB = 1'b0;

    task automatic advance(inout ex_t m, inout logic ll, input bit align);
        logic [85:0] o;
        if (reset) begin
            m  = '0;
            ll = 1'b0;
        end else if (Flush) begin
            m = '0;
        end else if (!Stall) begin
            o = expOut(m, ll, align);
            if (LLClear || (m.llsc && m.wr)) ll = 1'b0;
            else if (m.llsc && m.rd && !o[1]) ll = 1'b1;
            m = ex;
        end
    endtask

    task automatic chk(input string name, input logic [85:0] act, input logic [85:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        advance(mA, llA, 1'b1);
        advance(mB, llB, 1'b0);
        #1;
        chk("modelA", outA, expOut(mA, llA, 1'b1));
        chk("modelB", outB, expOut(mB, llB, 1'b0));
    endtask

    function automatic ex_t randEx();
        logic [95:0] r;
        ex_t e;
        r = {$urandom(), $urandom(), $urandom()};
        e = r[79:0];
        if ($urandom_range(3) == 0) e.alu = 32'($urandom_range(3));
        return e;
    endfunction

    function automatic ex_t mkLL(input logic [31:0] addr);
        ex_t e = '0;
        e.rd = 1'b1; e.llsc = 1'b1; e.rw = 1'b1; e.m2r = 1'b1; e.alu = addr; e.dst = 5'd5;
        return e;
    endfunction

    function automatic ex_t mkSC(input logic [31:0] addr);
        ex_t e = '0;
        e.wr = 1'b1; e.llsc = 1'b1; e.rw = 1'b1; e.alu = addr; e.rt = 32'hDEADBEEF; e.dst = 5'd6;
        return e;
    endfunction

    initial begin
        ex = randEx();
        LLClear = 1'b1;
        cycle();
        cycle();
        chk("reset A", outA, '0);
        chk("reset B", outB, '0);

        reset = 1'b0; LLClear = 1'b0;
        ex = '0; ex.wr = 1'b1; ex.byt = 1'b1; ex.alu = 32'h1002; ex.rt = 32'h11223344;
        cycle();
        chk("SB data", 86'(A_StoreData), 86'(32'h44444444));
        chk("SB be", 86'(A_ByteEnable), 86'(4'b0100));
        chk("SB wr", 86'(A_MemWrite), 86'(1'b1));

        ex.byt = 1'b0; ex.half = 1'b1;
        cycle();
        chk("SH data", 86'(A_StoreData), 86'(32'h33443344));
        chk("SH be", 86'(A_ByteEnable), 86'(4'b1100));

        ex = '0; ex.rd = 1'b1; ex.rw = 1'b1; ex.m2r = 1'b1; ex.alu = 32'h1002;
        cycle();
        chk("LW adel A", 86'({A_ExcAdEL, A_Exception, A_MemRead, A_RegWrite, A_ByteEnable}),
            86'(8'b1100_0000));
        chk("LW noalign B", 86'({B_ExcAdEL, B_Exception, B_MemRead, B_RegWrite, B_ByteEnable}),
            86'(8'b0011_1111));

        ex = mkLL(32'h2000);
        cycle();
        ex = mkSC(32'h2000);
        cycle();
        chk("SC ok", 86'({A_MemWrite, A_LLBit, A_RegWrite, A_ByteEnable, A_ALUResult}),
            86'({3'b111, 4'b1111, 32'd1}));
        cycle();
        chk("SC again", 86'({A_MemWrite, A_LLBit, A_ByteEnable, A_ALUResult}),
            86'({2'b00, 4'b0000, 32'd0}));

        ex = mkLL(32'h2000);
        cycle();
        ex = '0;
        cycle();
        chk("LL sets", 86'(A_LLBit), 86'(1'b1));
        LLClear = 1'b1;
        cycle();
        LLClear = 1'b0;
        chk("LLClear", 86'(A_LLBit), 86'(1'b0));
        ex = mkSC(32'h2000);
        cycle();
        chk("SC after clear", 86'({A_MemWrite, A_ALUResult}), 86'({1'b0, 32'd0}));

        ex = mkLL(32'h2000);
        cycle();
        ex = '0; LLClear = 1'b1;
        cycle();
        LLClear = 1'b0;
        chk("LL vs LLClear", 86'(A_LLBit), 86'(1'b0));

        ex = '0; ex.wr = 1'b1; ex.alu = 32'h3000; ex.rt = 32'h55667788;
        cycle();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex = randEx();
            cycle();
            chk("stall hold", 86'({A_MemWrite, A_ALUResult, A_StoreData}),
                86'({1'b1, 32'h3000, 32'h55667788}));
        end
        Flush = 1'b1;
        cycle();
        chk("stall+flush A", 86'(outA[85:1]), '0);
        chk("stall+flush B", 86'(outB[85:1]), '0);
        Flush = 1'b0; Stall = 1'b0;

        ex = '0; ex.trap = 1'b1; ex.tcond = 1'b1; ex.alu = 32'd1;
        cycle();
        chk("trap taken", 86'({A_ExcTrap, A_Exception}), 86'(2'b11));
        ex.tcond = 1'b0;
        cycle();
        chk("trap not taken", 86'({A_ExcTrap, A_Exception}), 86'(2'b00));
        ex = '0; ex.ov = 1'b1; ex.rw = 1'b1; ex.alu = 32'd5;
        cycle();
        chk("overflow", 86'({A_RegWrite, A_ExcOv, A_Exception}), 86'(3'b011));

        for (int i = 0; i < 600; i++) begin
            ex      = randEx();
            reset   = ($urandom_range(63) == 0);
            Flush   = ($urandom_range(9) == 0);
            Stall   = ($urandom_range(4) == 0);
            LLClear = ($urandom_range(11) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
